// File: rtl/image_exchange_engine.sv
// image_exchange_engine
//   Exchange-port initiator for the dual-port 1-bit image memory. When START
//   is accepted it sweeps the IMG_W x IMG_H image in raster order. For each
//   pixel it applies a 1x3 horizontal operator (NOT/ERODE/DILATE/EDGE) and
//   writes the result back to the same address.
//
//   Optional feature macro: IMAGE_EXCHANGE_ONES_CNT_EN adds ONES_CNT, a count
//   of result=1 pixels written in the last run.
//
// Ports
//   CLK       in   clock, posedge
//   RST       in   synchronous active-high reset
//   START     in   start request, sampled only in IDLE
//   OP[1:0]   in   00 NOT, 01 ERODE, 10 DILATE, 11 EDGE (latched at start)
//   BUSY      out  high from the cycle after acceptance through the DONE cycle
//   DONE      out  one-cycle completion pulse
//   A_1       out  exchange address (read and write)
//   DI_1      out  exchange write data, registered (valid the cycle after WE_1)
//   WE_1      out  exchange write enable
//   DQ_1      in   exchange read data, combinational MEM[A_1]
//   ONES_CNT  out  (macro only) number of ones written in the last run
//
// State | meaning
//   IDLE   | waiting for START
//   RD     | read pixel A_1 into the window
//   WR     | write-request for pixel A_1; result loaded into DI_1
//   COMMIT | memory commits the last pixel; no request
//   FIN    | DONE pulse
module image_exchange_engine #(
  parameter int A_W   = 5,
  parameter int IMG_W = 8,
  parameter int IMG_H = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           START,
  input  logic [1:0]     OP,
  output logic           BUSY,
  output logic           DONE,
  output logic [A_W-1:0] A_1,
  output logic           DI_1,
  output logic           WE_1,
  input  logic           DQ_1
`ifdef IMAGE_EXCHANGE_ONES_CNT_EN
  ,
  output logic [A_W:0]   ONES_CNT
`endif
);

  localparam int N  = IMG_W * IMG_H;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  localparam logic [A_W-1:0] IDX_LAST = A_W'(N - 1);
  localparam logic [A_W-1:0] IDX_PEN  = A_W'(N - 2);
  localparam logic [CW-1:0]  COL_LAST = CW'(IMG_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_COMMIT,
    S_FIN
  } state_t;

  state_t         state_q, state_d;
  logic [A_W-1:0] rd_q, rd_d;
  logic [A_W-1:0] wr_q, wr_d;
  logic [CW-1:0]  col_q, col_d;
  logic [2:0]     win_q, win_d;   // [2]=left, [1]=centre, [0]=right
  logic [1:0]     op_q, op_d;
  logic           di_q, di_d;
`ifdef IMAGE_EXCHANGE_ONES_CNT_EN
  logic [A_W:0]   ones_q, ones_d;
`endif

  logic pix_l, pix_c, pix_r, result;

  // Border masking: no wrap across rows.
  always_comb begin
    pix_l = (col_q == '0) ? 1'b0 : win_q[2];
    pix_c = win_q[1];
    pix_r = (col_q == COL_LAST) ? 1'b0 : win_q[0];
    case (op_q)
      2'b00:   result = ~pix_c;
      2'b01:   result = pix_l & pix_c & pix_r;
      2'b10:   result = pix_l | pix_c | pix_r;
      default: result = pix_c & ~(pix_l & pix_r);
    endcase
  end

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    col_d   = col_q;
    win_d   = win_q;
    op_d    = op_q;
    di_d    = di_q;
`ifdef IMAGE_EXCHANGE_ONES_CNT_EN
    ones_d  = ones_q;
`endif
    BUSY    = (state_q != S_IDLE);
    DONE    = (state_q == S_FIN);
    WE_1    = (state_q == S_WR);
    case (state_q)
      S_RD:     A_1 = rd_q;
      S_WR:     A_1 = wr_q;
      S_COMMIT: A_1 = IDX_LAST;
      default:  A_1 = '0;
    endcase

    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_RD;
          rd_d    = '0;
          wr_d    = '0;
          col_d   = '0;
          win_d   = '0;
          op_d    = OP;
`ifdef IMAGE_EXCHANGE_ONES_CNT_EN
          ones_d  = '0;
`endif
        end
      end
      S_RD: begin
        win_d   = {win_q[1:0], DQ_1};
        rd_d    = rd_q + A_W'(1);
        // Two reads prime the window before the first write.
        state_d = (rd_q == '0) ? S_RD : S_WR;
      end
      S_WR: begin
        di_d  = result;
        wr_d  = wr_q + A_W'(1);
        col_d = (col_q == COL_LAST) ? '0 : col_q + CW'(1);
`ifdef IMAGE_EXCHANGE_ONES_CNT_EN
        ones_d = ones_q + {{A_W{1'b0}}, result};
`endif
        if (wr_q == IDX_LAST) begin
          state_d = S_COMMIT;
        end else if (wr_q == IDX_PEN) begin
          // Nothing left to read: shift a zero in for the last pixel.
          state_d = S_WR;
          win_d   = {win_q[1:0], 1'b0};
        end else begin
          state_d = S_RD;
        end
      end
      S_COMMIT: state_d = S_FIN;
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      rd_q    <= '0;
      wr_q    <= '0;
      col_q   <= '0;
      win_q   <= '0;
      op_q    <= '0;
      di_q    <= 1'b0;
`ifdef IMAGE_EXCHANGE_ONES_CNT_EN
      ones_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      col_q   <= col_d;
      win_q   <= win_d;
      op_q    <= op_d;
      di_q    <= di_d;
`ifdef IMAGE_EXCHANGE_ONES_CNT_EN
      ones_q  <= ones_d;
`endif
    end
  end

  assign DI_1 = di_q;
`ifdef IMAGE_EXCHANGE_ONES_CNT_EN
  assign ONES_CNT = ones_q;
`endif

endmodule

// File: tb/tb_image_exchange_engine.sv
module tb_image_exchange_engine;

  logic       CLK = 1'b0;
  logic       RST, START;
  logic [1:0] OP;
  logic       BUSY, DONE, DI_1, WE_1, DQ_1;
  logic [4:0] A_1;
`ifdef IMAGE_EXCHANGE_ONES_CNT_EN
  logic [5:0] ones_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Memory model: pixel k lives at mem[k].
  logic [31:0] mem;
  logic [4:0]  a_reg;
  logic        we_reg, rst_reg;
  logic        host_load = 1'b0;
  logic [31:0] host_img = '0;
  logic [31:0] orig = '0;
  logic [1:0]  run_op = '0;

  always #5 CLK = ~CLK;

  assign DQ_1 = mem[A_1];

  image_exchange_engine #(.A_W(5), .IMG_W(8), .IMG_H(4)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .OP    (OP),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .A_1   (A_1),
    .DI_1  (DI_1),
    .WE_1  (WE_1),
    .DQ_1  (DQ_1)
`ifdef IMAGE_EXCHANGE_ONES_CNT_EN
    ,
    .ONES_CNT (ones_cnt)
`endif
  );

  // Memory registers A_1/WE_1 and samples DI_1 one cycle later.
  always @(posedge CLK) begin
    a_reg   <= A_1;
    we_reg  <= WE_1;
    rst_reg <= RST;
    if (host_load) mem <= host_img;
    else if (we_reg) mem[a_reg] <= DI_1;
  end

  function automatic logic pix_res(input logic [31:0] img, input logic [1:0] op, input int k);
    logic l, c, r;
    c = img[k];
    l = 1'b0;
    r = 1'b0;
    if (k % 8 != 0) l = img[k-1];
    if (k % 8 != 7) r = img[k+1];
    case (op)
      2'b00:   return ~c;
      2'b01:   return l & c & r;
      2'b10:   return l | c | r;
      default: return c & ~(l & r);
    endcase
  endfunction

  // Literal written left to right as pixel 0..31.
  function automatic logic [31:0] px(input logic [31:0] lit);
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = lit[31-i];
    return v;
  endfunction

  // Protocol monitor: data in the cycle after a write request.
  always @(negedge CLK) begin
    if (we_reg === 1'b1 && rst_reg === 1'b0) begin
      checks++;
      assert (DI_1 === pix_res(orig, run_op, int'(a_reg))) else begin
        errors++;
        $error("FAIL di_1 addr=%0d observed=%b expected=%b", a_reg, DI_1,
               pix_res(orig, run_op, int'(a_reg)));
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [31:0] lit);
    @(negedge CLK);
    host_img  = px(lit);
    host_load = 1'b1;
    @(negedge CLK);
    host_load = 1'b0;
  endtask

  task automatic run(input string name, input logic [1:0] op, input int wait_exp,
                     input int poke_at, input int rst_at, input logic [31:0] exp_lit);
    int w, cyc, wes;
    orig   = mem;
    run_op = op;
    OP     = op;
    START  = 1'b1;
    w = 0;
    do begin
      @(negedge CLK);
      w++;
    end while (BUSY !== 1'b1 && w < 5);
    START = 1'b0;
    chk({name, "_start_wait"}, w, wait_exp);
    chk({name, "_addr_c1"}, {27'd0, A_1}, 32'd0);
    cyc = 1;
    wes = 0;
    while (DONE !== 1'b1 && cyc < 200) begin
      if (WE_1 === 1'b1) wes++;
      if (cyc == poke_at) begin
        START = 1'b1;
        OP    = ~op;
      end
      if (cyc == poke_at + 1) START = 1'b0;
      if (cyc == rst_at) RST = 1'b1;
      if (cyc == rst_at + 1) begin
        chk({name, "_rst_busy"}, {31'd0, BUSY}, 32'd0);
        chk({name, "_rst_we"}, {31'd0, WE_1}, 32'd0);
        RST = 1'b0;
      end
      @(negedge CLK);
      cyc++;
    end
    if (rst_at > 0) begin
      chk({name, "_no_done"}, {31'd0, DONE}, 32'd0);
    end else begin
      chk({name, "_done_cyc"}, cyc, 66);
      chk({name, "_we_cnt"}, wes, 32);
      chk({name, "_image"}, mem, px(exp_lit));
    end
  endtask

  localparam logic [31:0] PRE = 32'b00001111_10101111_00000000_00000000;

  initial begin
    RST   = 1'b1;
    START = 1'b0;
    OP    = 2'b00;
    repeat (3) @(negedge CLK);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    chk("rst_we",   {31'd0, WE_1}, 32'd0);
    chk("rst_di",   {31'd0, DI_1}, 32'd0);
    chk("rst_addr", {27'd0, A_1},  32'd0);
`ifdef IMAGE_EXCHANGE_ONES_CNT_EN
    chk("rst_ones", {26'd0, ones_cnt}, 32'd0);
`endif
    RST = 1'b0;

    load(PRE);
    run("erode", 2'b01, 1, -1, -1, 32'b00000110_00000110_00000000_00000000);
    load(PRE);
    run("dilate", 2'b10, 1, -1, -1, 32'b00011111_11111111_00000000_00000000);
    load(PRE);
    run("edge", 2'b11, 1, -1, -1, 32'b00001001_10101001_00000000_00000000);

    load(32'hFFFF_FFFF);
    run("not1", 2'b00, 1, -1, -1, 32'h0000_0000);
`ifdef IMAGE_EXCHANGE_ONES_CNT_EN
    chk("ones_zero", {26'd0, ones_cnt}, 32'd0);
`endif
    // START raised in the FIN cycle: accepted one IDLE cycle later.
    run("not2", 2'b00, 2, -1, -1, 32'hFFFF_FFFF);
`ifdef IMAGE_EXCHANGE_ONES_CNT_EN
    chk("ones_32", {26'd0, ones_cnt}, 32'd32);
`endif

    load(PRE);
    run("poke", 2'b01, 1, 10, -1, 32'b00000110_00000110_00000000_00000000);

    load(PRE);
    run("reset", 2'b10, 1, -1, 20, 32'h0);
    load(PRE);
    run("after_rst", 2'b10, 1, -1, -1, 32'b00011111_11111111_00000000_00000000);

    repeat (2) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
